mips_lsu: RTL



---
 rtl/mips_lsu_if.sv | 25 ++
 rtl/mips_lsu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_lsu_if.sv
// Memory-side handshake bundle for mips_lsu: request channel (Address/MemRead/MemWrite/strobes)
// and the data-response channel (Read_data/Valid/Ack).
interface mips_lsu_if #(
  parameter int unsigned ADDR_W = 32
);
  logic [ADDR_W-1:0] Address;
  logic              MemWrite;
  logic [31:0]       Write_data;
  logic [3:0]        Write_strb;
  logic              MemRead;
  logic              Mem_Req_Ack;
  logic [31:0]       Read_data;
  logic              Read_data_Valid;
  logic              Read_data_Ack;

  modport master (
    output Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ack,
    input  Mem_Req_Ack, Read_data, Read_data_Valid
  );

  modport slave (
    input  Address, MemWrite, Write_data, Write_strb, MemRead, Read_data_Ack,
    output Mem_Req_Ack, Read_data, Read_data_Valid
  );
endinterface

// File: rtl/mips_lsu.sv
// Multi-cycle MIPS load/store unit: lane steering, LWL/LWR merge, misalignment check, timeout.
// Optional performance counters are enabled by defining LSU_PERF_EN.
module mips_lsu #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned ALIGN_CHECK = 1,
  parameter int unsigned TIMEOUT     = 0,
  parameter int unsigned TO_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt_value,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err,
  output logic [31:0]       result,
`ifdef LSU_PERF_EN
  output logic [31:0]       perf_ld_cnt,
  output logic [31:0]       perf_st_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  mips_lsu_if.master        mem
);

  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StReq  = 4'b0010,
    StResp = 4'b0100,
    StDone = 4'b1000
  } state_e;

  state_e            state_q;
  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       rt_q;
  logic [31:0]       result_q;
  logic [1:0]        err_q;
  logic              busy_q, done_q, mem_rd_q, mem_wr_q, rd_ack_q;
  logic [TO_W-1:0]   cnt_q;

  logic [1:0]  b;
  logic [4:0]  bsh, rsh;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val, wr_data;
  logic [3:0]  wr_strb;
  logic        misaligned, timed_out;

  assign b   = addr_q[1:0];
  assign bsh = {b, 3'b000};
  // 8*(3-b) for a 2-bit b is just the inverted lane index scaled by 8.
  assign rsh = {~b, 3'b000};

  assign ld_byte = 8'(mem.Read_data >> bsh);
  assign ld_half = addr_q[1] ? mem.Read_data[31:16] : mem.Read_data[15:0];

  assign misaligned = ((op[1:0] == 2'b01) && addr[0]) ||
                      ((op[2:0] == 3'b011) && (addr[1:0] != 2'b00));
  assign timed_out  = (TIMEOUT != 0) && (cnt_q == TO_W'(TIMEOUT - 1));

  always_comb begin
    ld_val = mem.Read_data;
    case (op_q[2:0])
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_val = {16'b0, ld_half};
      3'b010:  ld_val = (mem.Read_data << rsh) | (rt_q & (32'h00FF_FFFF >> bsh));
      3'b110:  ld_val = (mem.Read_data >> bsh) | (rt_q & ~(32'hFFFF_FFFF >> bsh));
      default: ;
    endcase
  end

  always_comb begin
    wr_data = rt_q;
    wr_strb = 4'b1111;
    case (op_q[2:0])
      3'b000, 3'b100: begin
        wr_data = {4{rt_q[7:0]}};
        wr_strb = 4'b0001 << b;
      end
      3'b001, 3'b101: begin
        wr_data = {2{rt_q[15:0]}};
        wr_strb = b[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        wr_data = rt_q >> rsh;
        wr_strb = 4'b1111 >> ~b;
      end
      3'b110: begin
        wr_data = rt_q << bsh;
        wr_strb = 4'b1111 << b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      addr_q   <= '0;
      rt_q     <= '0;
      result_q <= '0;
      err_q    <= 2'b00;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mem_rd_q <= 1'b0;
      mem_wr_q <= 1'b0;
      rd_ack_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q   <= op;
            addr_q <= addr;
            rt_q   <= rt_value;
            busy_q <= 1'b1;
            if ((ALIGN_CHECK != 0) && misaligned) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 2'b01;
            end else begin
              state_q  <= StReq;
              cnt_q    <= '0;
              mem_rd_q <= ~op[3];
              mem_wr_q <= op[3];
            end
          end
        end
        StReq: begin
          if (mem.Mem_Req_Ack) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            cnt_q    <= '0;
            if (op_q[3]) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 2'b00;
            end else begin
              state_q  <= StResp;
              rd_ack_q <= 1'b1;
            end
          end else if (timed_out) begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            state_q  <= StDone;
            done_q   <= 1'b1;
            err_q    <= 2'b10;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        StResp: begin
          if (mem.Read_data_Valid) begin
            rd_ack_q <= 1'b0;
            result_q <= ld_val;
            state_q  <= StDone;
            done_q   <= 1'b1;
            err_q    <= 2'b00;
          end else if (timed_out) begin
            rd_ack_q <= 1'b0;
            state_q  <= StDone;
            done_q   <= 1'b1;
            err_q    <= 2'b10;
          end else begin
            cnt_q <= cnt_q + TO_W'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

  assign mem.Address       = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem.MemRead       = mem_rd_q;
  assign mem.MemWrite      = mem_wr_q;
  assign mem.Write_data    = wr_data;
  assign mem.Write_strb    = wr_strb;
  assign mem.Read_data_Ack = rd_ack_q;

`ifdef LSU_PERF_EN
  logic [31:0] perf_ld_q, perf_st_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ld_q    <= '0;
      perf_st_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      if (done_q && (err_q == 2'b00)) begin
        if (op_q[3]) perf_st_q <= perf_st_q + 32'd1;
        else         perf_ld_q <= perf_ld_q + 32'd1;
      end
      if ((state_q == StReq) || (state_q == StResp)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_ld_cnt    = perf_ld_q;
  assign perf_st_cnt    = perf_st_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
